code_sequence_encoder: RTL and testbench
========================================

CODE_SEQUENCE_ENCODER -- requirements
Module: code_sequence_encoder

Interface
REQ-001 Clock clk; reset Reset, synchronous, active-high.
REQ-002 Parameter GAP_CYCLES, default 0: idle cycles inserted between consecutive emitted codes; legal range 0..15.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 Reset  input  1  synchronous active-high reset.
REQ-005 Iniciar  input  1  single-cycle command: move to position Alvo.
REQ-006 Alvo  input  3  target position; legal values 1..5.
REQ-007 Fim  input  1  single-cycle command: emit terminal code.
REQ-008 Codigo  output  7  current line code; holds its value between emissions.
REQ-009 Controle  output  1  one-cycle strobe, high on each cycle a new Codigo is presented.
REQ-010 Posicao  output  3  last position emitted (0..5).
REQ-011 Ocupado  output  1  high while stepping or gapping.
REQ-012 Concluido  output  1  one-cycle pulse when Posicao reaches Alvo.
REQ-013 Travado  output  1  high after a terminal code is emitted; cleared only by Reset.
REQ-014 Erro_cmd  output  1  one-cycle pulse on a rejected command.

Function
REQ-015 Codes SHALL be: C1=7'h01, C2=7'h02, C3=7'h04, C4=7'h08, C5=7'h10, C6=7'h20, C7=7'h40, C8=7'h7F. Positions 1..5 map to C1..C5.
REQ-016 FSM states SHALL be IDLE, STEP, GAP, HALT.
REQ-017 IDLE + Iniciar, Alvo in 1..5, Alvo != Posicao -> STEP. The first code SHALL appear with Controle=1 on the next cycle.
REQ-018 Each STEP cycle SHALL move Posicao by exactly one (+1 if Alvo>Posicao, else -1). It SHALL emit the code of the new position with Controle=1. No position SHALL ever be skipped; from 0 the first code is always C1.
REQ-019 After each emitted code that does not reach Alvo:
  - GAP_CYCLES=0 -> next STEP immediately (codes on consecutive cycles).
  - GAP_CYCLES>0 -> GAP for exactly GAP_CYCLES cycles, with Controle=0 and Codigo held.
REQ-020 Posicao reaching Alvo -> Concluido=1 on the following cycle; return to IDLE. Latency from Iniciar to Concluido = |Alvo-Posicao| + (|Alvo-Posicao|-1)*GAP_CYCLES + 1 cycles.
REQ-021 The following SHALL each cause an Erro_cmd pulse next cycle with no state change:
  - Iniciar with Alvo in {0,6,7};
  - Iniciar with Alvo == Posicao;
  - Iniciar or Fim while Ocupado.
REQ-022 IDLE + Fim with Posicao in 1..3 -> emit C6. Posicao in 4..5 -> emit C8. Either case: Controle=1 next cycle, then HALT with Travado=1.
REQ-023 Fim with Posicao=0 -> Erro_cmd, no emission.
REQ-024 Fim and Iniciar in the same IDLE cycle -> Fim wins; Iniciar is discarded silently.
REQ-025 HALT SHALL ignore all commands without raising Erro_cmd. Codigo holds the terminal code.
REQ-026 Codigo SHALL never take a value outside C1..C8 except its reset value.

Reset
REQ-027 Reset SHALL have priority over all inputs and SHALL take effect from any state, including mid-step and HALT.
REQ-028 Reset values: state=IDLE, Codigo=7'h00, Controle=0, Posicao=0, Ocupado=0, Concluido=0, Travado=0, Erro_cmd=0, gap counter=0.

Configuration
REQ-029 Macro ERR_INJECT_EN.
  - When defined: input Injetar_erro (1 bit) SHALL exist. IDLE + Injetar_erro with Posicao in 1..5 -> emit C7 with Controle=1, then HALT. Injetar_erro has priority over Fim and Iniciar.
  - When undefined: the port SHALL be absent and C7 SHALL never be emitted.

Structure
REQ-030 Package code_seq_pkg SHALL hold the C1..C8 constants, the FSM state enum, and the position width (3).
REQ-031 Sub-module pos_to_code SHALL provide the combinational position(1..5)->code lookup, returning 7'h00 otherwise.

Verification
REQ-032 The bench SHALL cover these directed scenarios:
  - Reset, Iniciar Alvo=3, GAP_CYCLES=0 -> Codigo C1,C2,C3 on cycles 1,2,3 with Controle=1; Concluido at cycle 4; Posicao=3.
  - From Posicao=5, Iniciar Alvo=2, GAP_CYCLES=2 -> C4, 2 gap cycles, C3, 2 gap cycles, C2; Controle exactly 3 pulses.
  - Posicao=2 + Fim -> C6 (7'h20), Travado=1; later Iniciar ignored with Erro_cmd=0. Posicao=4 + Fim -> C8 (7'h7F).
  - Iniciar Alvo=6 -> Erro_cmd pulse, Posicao unchanged. Iniciar during stepping -> Erro_cmd, sequence unaffected.
  - Reset asserted mid-sequence (Posicao=2 heading to 5) -> next cycle all outputs at reset values; no further Controle.
  - ERR_INJECT_EN defined, Posicao=1, Injetar_erro and Fim together -> C7 (7'h40) emitted, HALT.

Source files
------------

// File: rtl/code_sequence_encoder_pkg.sv
// Shared definitions for the code sequence encoder: line codes, FSM states, widths.
// Latency: none (constants, types and a pure helper function only).
// Backpressure: none.
package code_seq_pkg;

    localparam int POS_W  = 3;
    localparam int CODE_W = 7;

    localparam logic [CODE_W-1:0] CODE_RST = 7'h00;
    localparam logic [CODE_W-1:0] C1 = 7'h01;
    localparam logic [CODE_W-1:0] C2 = 7'h02;
    localparam logic [CODE_W-1:0] C3 = 7'h04;
    localparam logic [CODE_W-1:0] C4 = 7'h08;
    localparam logic [CODE_W-1:0] C5 = 7'h10;
    localparam logic [CODE_W-1:0] C6 = 7'h20;
    localparam logic [CODE_W-1:0] C7 = 7'h40;
    localparam logic [CODE_W-1:0] C8 = 7'h7F;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        STEP = 2'd1,
        GAP  = 2'd2,
        HALT = 2'd3
    } state_t;

    // Positions 1..5 are the only ones that map to a line code.
    function automatic logic pos_in_range(input logic [POS_W-1:0] p);
        return (p >= 3'd1) && (p <= 3'd5);
    endfunction

endpackage

// File: rtl/code_sequence_encoder_if.sv
// Command/status bundle between the controller and the code sequence encoder.
// Latency: none (wires only). Injetar_erro exists only when ERR_INJECT_EN is defined.
// Backpressure: none; commands are single-cycle pulses, Ocupado tells the master to wait.
interface code_sequence_encoder_if;
    import code_seq_pkg::*;

    logic              Iniciar;
    logic [POS_W-1:0]  Alvo;
    logic              Fim;
`ifdef ERR_INJECT_EN
    logic              Injetar_erro;
`endif
    logic [CODE_W-1:0] Codigo;
    logic              Controle;
    logic [POS_W-1:0]  Posicao;
    logic              Ocupado;
    logic              Concluido;
    logic              Travado;
    logic              Erro_cmd;

`ifdef ERR_INJECT_EN
    modport master (output Iniciar, Alvo, Fim, Injetar_erro,
                    input  Codigo, Controle, Posicao, Ocupado, Concluido, Travado, Erro_cmd);
    modport slave  (input  Iniciar, Alvo, Fim, Injetar_erro,
                    output Codigo, Controle, Posicao, Ocupado, Concluido, Travado, Erro_cmd);
`else
    modport master (output Iniciar, Alvo, Fim,
                    input  Codigo, Controle, Posicao, Ocupado, Concluido, Travado, Erro_cmd);
    modport slave  (input  Iniciar, Alvo, Fim,
                    output Codigo, Controle, Posicao, Ocupado, Concluido, Travado, Erro_cmd);
`endif

endinterface

// File: rtl/code_sequence_encoder_pos_to_code.sv
// Combinational lookup from position 1..5 to line code C1..C5; anything else gives 7'h00.
// Latency: combinational, zero cycles.
// Backpressure: none.
module pos_to_code
    import code_seq_pkg::*;
(
    input  logic [POS_W-1:0]  pos,
    output logic [CODE_W-1:0] code
);

    // One-hot line code per position; out-of-range positions fall back to the reset code.
    always_comb begin
        code = CODE_RST;
        case (pos)
            3'd1:    code = C1;
            3'd2:    code = C2;
            3'd3:    code = C3;
            3'd4:    code = C4;
            3'd5:    code = C5;
            default: code = CODE_RST;
        endcase
    end

endmodule

// File: rtl/code_sequence_encoder.sv
// Steps a position one unit at a time toward a target, emitting a line code per step; Fim emits a terminal code and locks.
// Latency: first code one cycle after Iniciar, then one code per 1+GAP_CYCLES cycles; Concluido one cycle after the last code.
// Backpressure: none; commands while Ocupado are rejected with Erro_cmd. ERR_INJECT_EN adds Injetar_erro (emits C7, locks).
module code_sequence_encoder
    import code_seq_pkg::*;
#(
    parameter int GAP_CYCLES = 0
) (
    input  logic                    clk,
    input  logic                    Reset,
    code_sequence_encoder_if.slave  bus
);

    localparam logic [3:0] GAP_INIT = GAP_CYCLES[3:0];

    state_t            state_q, state_d;
    logic [POS_W-1:0]  pos_q, pos_d;
    logic [POS_W-1:0]  tgt_q, tgt_d;
    logic [CODE_W-1:0] code_q, code_d;
    logic [3:0]        gap_q, gap_d;
    logic              ctl_q, ctl_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    logic              do_step;
    logic              inject;
    logic [POS_W-1:0]  step_tgt;
    logic [POS_W-1:0]  step_pos;
    logic [CODE_W-1:0] step_code;

`ifdef ERR_INJECT_EN
    assign inject = bus.Injetar_erro;
`else
    assign inject = 1'b0;
`endif

    // The first step is taken straight from IDLE, so the target comes from the port there.
    assign step_tgt = (state_q == IDLE) ? bus.Alvo : tgt_q;
    assign step_pos = (step_tgt > pos_q) ? pos_q + 3'd1 : pos_q - 3'd1;

    pos_to_code u_pos_to_code (
        .pos  (step_pos),
        .code (step_code)
    );

    // Next-state and next-output decode; every register holds unless a branch says otherwise.
    always_comb begin
        state_d = state_q;
        pos_d   = pos_q;
        tgt_d   = tgt_q;
        code_d  = code_q;
        gap_d   = gap_q;
        ctl_d   = 1'b0;
        done_d  = 1'b0;
        err_d   = 1'b0;
        do_step = 1'b0;
        case (state_q)
            IDLE: begin
                if (inject) begin
                    if (pos_in_range(pos_q)) begin
                        code_d  = C7;
                        ctl_d   = 1'b1;
                        state_d = HALT;
                    end else begin
                        err_d = 1'b1;
                    end
                end else if (bus.Fim) begin
                    // Fim outranks Iniciar; a simultaneous Iniciar is dropped without error.
                    if ((pos_q >= 3'd1) && (pos_q <= 3'd3)) begin
                        code_d  = C6;
                        ctl_d   = 1'b1;
                        state_d = HALT;
                    end else if (pos_in_range(pos_q)) begin
                        code_d  = C8;
                        ctl_d   = 1'b1;
                        state_d = HALT;
                    end else begin
                        err_d = 1'b1;
                    end
                end else if (bus.Iniciar) begin
                    if (!pos_in_range(bus.Alvo) || (bus.Alvo == pos_q)) begin
                        err_d = 1'b1;
                    end else begin
                        tgt_d   = bus.Alvo;
                        do_step = 1'b1;
                    end
                end
            end
            STEP: begin
                err_d = bus.Iniciar | bus.Fim;
                if (pos_q == tgt_q) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    do_step = 1'b1;
                end
            end
            GAP: begin
                err_d = bus.Iniciar | bus.Fim;
                if (gap_q <= 4'd1) begin
                    gap_d   = 4'd0;
                    state_d = STEP;
                end else begin
                    gap_d = gap_q - 4'd1;
                end
            end
            default: begin
                // HALT: locked until Reset, every command ignored silently.
            end
        endcase
        if (do_step) begin
            pos_d  = step_pos;
            code_d = step_code;
            ctl_d  = 1'b1;
            // No gap after the code that lands on the target: Concluido follows directly.
            if ((step_pos == step_tgt) || (GAP_INIT == 4'd0)) begin
                state_d = STEP;
            end else begin
                state_d = GAP;
                gap_d   = GAP_INIT;
            end
        end
    end

    // State and registered outputs; synchronous reset wins over every command.
    always_ff @(posedge clk) begin
        if (Reset) begin
            state_q <= IDLE;
            pos_q   <= '0;
            tgt_q   <= '0;
            code_q  <= CODE_RST;
            gap_q   <= 4'd0;
            ctl_q   <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pos_q   <= pos_d;
            tgt_q   <= tgt_d;
            code_q  <= code_d;
            gap_q   <= gap_d;
            ctl_q   <= ctl_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign bus.Codigo    = code_q;
    assign bus.Controle  = ctl_q;
    assign bus.Posicao   = pos_q;
    assign bus.Ocupado   = (state_q == STEP) || (state_q == GAP);
    assign bus.Concluido = done_q;
    assign bus.Travado   = (state_q == HALT);
    assign bus.Erro_cmd  = err_q;

endmodule

// File: tb/tb_code_sequence_encoder.sv
// Directed bench: two encoders (GAP_CYCLES 0 and 2) driven one at a time; expected events queued, monitor pops and compares.
// Latency: expected events carry the absolute cycle they must appear on.
// Backpressure: none; commands are single-cycle pulses.
module tb_code_sequence_encoder;

    logic clk;
    logic rst0;
    logic rst1;
    int   cyc;
    int   checks;
    int   errors;
    int   ctl_cnt [2];

    typedef struct {
        int         dut;
        int         cyc;
        logic [6:0] code;
        logic [2:0] pos;
    } exp_t;

    exp_t em_q[$];
    exp_t dn_q[$];
    exp_t er_q[$];

    code_sequence_encoder_if bus0 ();
    code_sequence_encoder_if bus1 ();

    code_sequence_encoder #(.GAP_CYCLES(0)) u_dut0 (.clk(clk), .Reset(rst0), .bus(bus0));
    code_sequence_encoder #(.GAP_CYCLES(2)) u_dut1 (.clk(clk), .Reset(rst1), .bus(bus1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic void unexpected(input string name, input int d);
        checks++;
        errors++;
        $display("FAIL %s: unexpected event on dut%0d at cycle %0d", name, d, cyc);
    endfunction

    function automatic void observe(input int d, input logic ctl, input logic [6:0] code,
                                    input logic [2:0] pos, input logic done, input logic err);
        exp_t e;
        if (ctl === 1'b1) begin
            ctl_cnt[d]++;
            if (em_q.size() == 0) unexpected("emit", d);
            else begin
                e = em_q.pop_front();
                chk("emit.dut", 32'(d), 32'(e.dut));
                chk("emit.cyc", 32'(cyc), 32'(e.cyc));
                chk("emit.code", 32'(code), 32'(e.code));
                chk("emit.pos", 32'(pos), 32'(e.pos));
            end
        end
        if (done === 1'b1) begin
            if (dn_q.size() == 0) unexpected("done", d);
            else begin
                e = dn_q.pop_front();
                chk("done.dut", 32'(d), 32'(e.dut));
                chk("done.cyc", 32'(cyc), 32'(e.cyc));
                chk("done.pos", 32'(pos), 32'(e.pos));
            end
        end
        if (err === 1'b1) begin
            if (er_q.size() == 0) unexpected("err", d);
            else begin
                e = er_q.pop_front();
                chk("err.dut", 32'(d), 32'(e.dut));
                chk("err.cyc", 32'(cyc), 32'(e.cyc));
                chk("err.pos", 32'(pos), 32'(e.pos));
            end
        end
    endfunction

    // Monitor: sample both encoders on the falling edge, away from the launching edge.
    initial begin
        forever begin
            @(negedge clk);
            observe(0, bus0.Controle, bus0.Codigo, bus0.Posicao, bus0.Concluido, bus0.Erro_cmd);
            observe(1, bus1.Controle, bus1.Codigo, bus1.Posicao, bus1.Concluido, bus1.Erro_cmd);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic ex_emit(input int d, input int c, input logic [6:0] code, input logic [2:0] pos);
        em_q.push_back('{dut: d, cyc: c, code: code, pos: pos});
    endtask

    task automatic ex_done(input int d, input int c, input logic [2:0] pos);
        dn_q.push_back('{dut: d, cyc: c, code: 7'h00, pos: pos});
    endtask

    task automatic ex_err(input int d, input int c, input logic [2:0] pos);
        er_q.push_back('{dut: d, cyc: c, code: 7'h00, pos: pos});
    endtask

    task automatic drive(input int d, input logic ini, input logic [2:0] alvo, input logic fim);
        if (d == 0) begin
            bus0.Iniciar = ini;
            bus0.Alvo    = alvo;
            bus0.Fim     = fim;
        end else begin
            bus1.Iniciar = ini;
            bus1.Alvo    = alvo;
            bus1.Fim     = fim;
        end
    endtask

    // One-cycle command; returns one cycle later with the first response already visible.
    task automatic pulse(input int d, input logic ini, input logic [2:0] alvo, input logic fim);
        drive(d, ini, alvo, fim);
        tick(1);
        drive(d, 1'b0, 3'd0, 1'b0);
    endtask

    int b;
    int n0;

    initial begin
        cyc = 0; checks = 0; errors = 0;
        ctl_cnt[0] = 0; ctl_cnt[1] = 0;
        rst0 = 1'b1; rst1 = 1'b1;
        drive(0, 1'b0, 3'd0, 1'b0);
        drive(1, 1'b0, 3'd0, 1'b0);
`ifdef ERR_INJECT_EN
        bus0.Injetar_erro = 1'b0;
        bus1.Injetar_erro = 1'b0;
`endif
        tick(3);
        chk("reset.dut0", 32'({bus0.Codigo, bus0.Controle, bus0.Posicao, bus0.Ocupado,
                               bus0.Concluido, bus0.Travado, bus0.Erro_cmd}), 32'd0);
        chk("reset.dut1", 32'({bus1.Codigo, bus1.Controle, bus1.Posicao, bus1.Ocupado,
                               bus1.Concluido, bus1.Travado, bus1.Erro_cmd}), 32'd0);
        rst0 = 1'b0; rst1 = 1'b0;
        tick(1);

        // 0 -> 3 with no gap: C1,C2,C3 on consecutive cycles, Concluido one later.
        b = cyc;
        ex_emit(0, b + 1, 7'h01, 3'd1); ex_emit(0, b + 2, 7'h02, 3'd2);
        ex_emit(0, b + 3, 7'h04, 3'd3); ex_done(0, b + 4, 3'd3);
        pulse(0, 1'b1, 3'd3, 1'b0);
        chk("step.ocupado", 32'(bus0.Ocupado), 32'd1);
        tick(5);
        chk("step.pos", 32'(bus0.Posicao), 32'd3);
        chk("step.idle", 32'(bus0.Ocupado), 32'd0);

        // Rejected starts: out-of-range targets and target equal to the current position.
        b = cyc; ex_err(0, b + 1, 3'd3); pulse(0, 1'b1, 3'd6, 1'b0); tick(1);
        b = cyc; ex_err(0, b + 1, 3'd3); pulse(0, 1'b1, 3'd0, 1'b0); tick(1);
        b = cyc; ex_err(0, b + 1, 3'd3); pulse(0, 1'b1, 3'd3, 1'b0); tick(1);
        chk("err.pos_kept", 32'(bus0.Posicao), 32'd3);

        // 3 -> 1 with Iniciar and Fim arriving while busy; the sequence must not be disturbed.
        b = cyc;
        ex_emit(0, b + 1, 7'h02, 3'd2); ex_emit(0, b + 2, 7'h01, 3'd1);
        ex_err(0, b + 2, 3'd1); ex_err(0, b + 3, 3'd1); ex_done(0, b + 3, 3'd1);
        pulse(0, 1'b1, 3'd1, 1'b0);
        pulse(0, 1'b1, 3'd5, 1'b0);
        pulse(0, 1'b0, 3'd0, 1'b1);
        tick(2);
        chk("busy.pos", 32'(bus0.Posicao), 32'd1);

        // 1 -> 2, then Fim together with Iniciar: Fim wins, C6, locked.
        b = cyc; ex_emit(0, b + 1, 7'h02, 3'd2); ex_done(0, b + 2, 3'd2);
        pulse(0, 1'b1, 3'd2, 1'b0); tick(2);
        b = cyc; ex_emit(0, b + 1, 7'h20, 3'd2);
        pulse(0, 1'b1, 3'd5, 1'b1);
        chk("fim.travado", 32'(bus0.Travado), 32'd1);
        pulse(0, 1'b1, 3'd4, 1'b0);
        pulse(0, 1'b0, 3'd0, 1'b1);
        tick(2);
        chk("halt.code", 32'(bus0.Codigo), 32'h20);
        chk("halt.travado", 32'(bus0.Travado), 32'd1);
        chk("halt.pos", 32'(bus0.Posicao), 32'd2);

        // Reset clears the lock; Fim at position 0 is an error and the paired Iniciar is dropped.
        rst0 = 1'b1; tick(1);
        chk("relock.reset", 32'({bus0.Codigo, bus0.Controle, bus0.Posicao, bus0.Ocupado,
                                 bus0.Concluido, bus0.Travado, bus0.Erro_cmd}), 32'd0);
        rst0 = 1'b0;
        b = cyc; ex_err(0, b + 1, 3'd0); pulse(0, 1'b1, 3'd3, 1'b1); tick(2);
        chk("fim0.pos", 32'(bus0.Posicao), 32'd0);

        // 0 -> 4, then Fim: C8.
        b = cyc;
        for (int k = 1; k <= 4; k++) ex_emit(0, b + k, 7'(1 << (k - 1)), 3'(k));
        ex_done(0, b + 5, 3'd4);
        pulse(0, 1'b1, 3'd4, 1'b0); tick(5);
        b = cyc; ex_emit(0, b + 1, 7'h7F, 3'd4);
        pulse(0, 1'b0, 3'd0, 1'b1); tick(1);
        chk("fim8.travado", 32'(bus0.Travado), 32'd1);

        // GAP_CYCLES=2: 0 -> 5 puts codes three cycles apart.
        b = cyc;
        for (int k = 1; k <= 5; k++) ex_emit(1, b + 1 + 3 * (k - 1), 7'(1 << (k - 1)), 3'(k));
        ex_done(1, b + 14, 3'd5);
        pulse(1, 1'b1, 3'd5, 1'b0); tick(15);

        // 5 -> 2: C4, two gap cycles, C3, two gap cycles, C2.
        n0 = ctl_cnt[1];
        b = cyc;
        ex_emit(1, b + 1, 7'h08, 3'd4); ex_emit(1, b + 4, 7'h04, 3'd3);
        ex_emit(1, b + 7, 7'h02, 3'd2); ex_done(1, b + 8, 3'd2);
        pulse(1, 1'b1, 3'd2, 1'b0);
        tick(1);
        chk("gap.code_held", 32'(bus1.Codigo), 32'h08);
        chk("gap.ctl_low", 32'(bus1.Controle), 32'd0);
        chk("gap.ocupado", 32'(bus1.Ocupado), 32'd1);
        tick(8);
        chk("gap.pulses", 32'(ctl_cnt[1] - n0), 32'd3);

        // 2 -> 5 interrupted by Reset in the first gap: nothing after C3.
        b = cyc; ex_emit(1, b + 1, 7'h04, 3'd3);
        pulse(1, 1'b1, 3'd5, 1'b0);
        tick(1);
        rst1 = 1'b1; tick(1);
        chk("midreset.dut1", 32'({bus1.Codigo, bus1.Controle, bus1.Posicao, bus1.Ocupado,
                                  bus1.Concluido, bus1.Travado, bus1.Erro_cmd}), 32'd0);
        rst1 = 1'b0;
        tick(10);
        chk("midreset.pos", 32'(bus1.Posicao), 32'd0);

`ifdef ERR_INJECT_EN
        // Injetar_erro outranks Fim and Iniciar: C7, locked.
        rst0 = 1'b1; tick(1); rst0 = 1'b0;
        b = cyc; ex_emit(0, b + 1, 7'h01, 3'd1); ex_done(0, b + 2, 3'd1);
        pulse(0, 1'b1, 3'd1, 1'b0); tick(2);
        b = cyc; ex_emit(0, b + 1, 7'h40, 3'd1);
        bus0.Injetar_erro = 1'b1;
        pulse(0, 1'b1, 3'd3, 1'b1);
        bus0.Injetar_erro = 1'b0;
        tick(1);
        chk("inject.travado", 32'(bus0.Travado), 32'd1);
        chk("inject.code", 32'(bus0.Codigo), 32'h40);
`endif

        tick(3);
        while (em_q.size() != 0) begin
            void'(em_q.pop_front()); checks++; errors++;
            $display("FAIL emit.missing: expected code never appeared");
        end
        while (dn_q.size() != 0) begin
            void'(dn_q.pop_front()); checks++; errors++;
            $display("FAIL done.missing: expected Concluido never appeared");
        end
        while (er_q.size() != 0) begin
            void'(er_q.pop_front()); checks++; errors++;
            $display("FAIL err.missing: expected Erro_cmd never appeared");
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
